uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter. It accepts a byte-valid strobe and drives the 8-bit serializer's shift enable. It consumes the serializer's serial bit and done flag and computes optional even/odd parity. It muxes start, data, parity and stop bits onto the TX line. It sits between the TX register-file/FIFO read side and the UART line output, alongside the serializer, and gates that serializer's load through `busy`.

---
 rtl/uart_tx_ctrl.sv | 97 +++++++++
 tb/tb_uart_tx_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and
// stop bits, gating the external 8-bit serializer through ser_en and busy.
module uart_tx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] p_data,
    input  logic       data_valid,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic       busy,
    output logic       tx_out,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       par_bit_reg;
    logic       par_en_reg;
    logic       accept;
    logic [8:0] par_chain;

    // Parity seeded with par_typ so odd parity falls out of the same XOR chain.
    assign par_chain[0] = par_typ;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_parity
            assign par_chain[gi+1] = par_chain[gi] ^ p_data[gi];
        end
    endgenerate

    assign accept = (state_reg == IDLE) && data_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            par_bit_reg <= 1'b0;
            par_en_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                par_en_reg  <= par_en;
                par_bit_reg <= par_chain[8];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ser_en     = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        tx_out     = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (data_valid) begin
                    state_next = START;
                end
            end
            START: begin
                tx_out     = 1'b0;
                state_next = DATA;
            end
            DATA: begin
                ser_en = 1'b1;
                tx_out = ser_data;
                if (ser_done) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_out     = par_bit_reg;
                state_next = STOP;
            end
            STOP: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a simple serializer model feeds the DUT
// and every frame is compared cycle by cycle against its expected line image.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic       busy;
    logic       tx_out;
    logic       frame_done;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int prev_start = -1;
    int prev_len   = 0;

    uart_tx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .busy       (busy),
        .tx_out     (tx_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer environment: loads when the controller is not busy, shifts LSB first.
    logic [7:0] sh_reg;
    logic [3:0] cnt_reg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_reg  <= 8'h00;
            cnt_reg <= 4'd0;
        end else if (!busy && data_valid) begin
            sh_reg  <= p_data;
            cnt_reg <= 4'd0;
        end else if (ser_en) begin
            sh_reg  <= sh_reg >> 1;
            cnt_reg <= cnt_reg + 4'd1;
        end
    end

    assign ser_data = sh_reg[0];
    assign ser_done = ser_en && (cnt_reg == 4'd7);

    // mode 0: quiet, 1: data_valid pulses with p_data=0, 2: random junk on all inputs.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic pt, input int mode, input bit hold);
        logic [10:0] line;
        int          n;
        int          sen_cnt;
        int          errs0;
        errs0   = miscompares;
        sen_cnt = 0;
        n       = pe ? 11 : 10;
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = d[i];
        line[9]  = pe ? ((^d) ^ pt) : 1'b1;
        line[10] = 1'b1;

        p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_before busy=%b tx=%b required busy=0 tx=1", name, busy, tx_out);
        end

        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1 && hold && prev_start >= 0) begin
                vectors++;
                if (cyc - prev_start !== prev_len + 1) begin
                    miscompares++;
                    $display("FAIL %s start_period got=%0d required=%0d", name, cyc - prev_start, prev_len + 1);
                end
            end
            if (k == 1) begin
                prev_start = cyc;
                prev_len   = n;
            end
            vectors++;
            if (tx_out !== line[k-1]) begin
                miscompares++;
                $display("FAIL %s tx_out cycle=%0d got=%b required=%b", name, k, tx_out, line[k-1]);
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle=%0d got=%b required=1", name, k, busy);
            end
            vectors++;
            if (ser_en !== (k >= 2 && k <= 9)) begin
                miscompares++;
                $display("FAIL %s ser_en cycle=%0d got=%b required=%b", name, k, ser_en, (k >= 2 && k <= 9));
            end
            vectors++;
            if (frame_done !== (k == n)) begin
                miscompares++;
                $display("FAIL %s frame_done cycle=%0d got=%b required=%b", name, k, frame_done, (k == n));
            end
            if (ser_en === 1'b1) sen_cnt++;
            if (mode == 1) begin
                data_valid = 1'($urandom_range(0, 1));
                p_data     = 8'h00;
            end else if (mode == 2) begin
                data_valid = 1'($urandom_range(0, 1));
                p_data     = 8'($urandom);
                par_en     = 1'($urandom_range(0, 1));
                par_typ    = 1'($urandom_range(0, 1));
            end else begin
                data_valid = hold;
            end
            if (k == n) data_valid = hold;
        end

        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || tx_out !== 1'b1 || ser_en !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after busy=%b tx=%b ser_en=%b fd=%b required 0,1,0,0",
                     name, busy, tx_out, ser_en, frame_done);
        end
        vectors++;
        if (sen_cnt !== 8) begin
            miscompares++;
            $display("FAIL %s ser_en_cycles got=%0d required=8", name, sen_cnt);
        end
        $display("%s data=%02h par_en=%b par_typ=%b len=%0d errors=%0d",
                 name, d, pe, pt, n, miscompares - errs0);
    endtask

    task automatic test_reset();
        rst = 1'b0; p_data = 8'h00; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
        #2;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values tx=%b busy=%b ser_en=%b fd=%b required 1,0,0,0",
                     tx_out, busy, ser_en, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Start a frame and abort it in the middle of the data bits.
        p_data = 8'h3C; par_en = 1'b1; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (ser_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_data ser_en got=%b required=1", ser_en);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe tx=%b busy=%b ser_en=%b fd=%b required 1,0,0,0",
                     tx_out, busy, ser_en, frame_done);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            vectors++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || ser_en !== 1'b0 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle cycle=%0d tx=%b busy=%b ser_en=%b fd=%b", k, tx_out, busy, ser_en, frame_done);
            end
        end
        $display("reset abort-in-data checked");
    endtask

    task automatic test_even_parity();
        run_frame("even_parity", 8'hA5, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_odd_parity();
        run_frame("odd_parity", 8'h01, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_no_parity();
        run_frame("no_parity", 8'hFF, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_busy_gating();
        run_frame("busy_gating_par", 8'h96, 1'b1, 1'b1, 1, 1'b0);
        run_frame("busy_gating_nopar", 8'h5A, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_frame("random", 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        prev_start = -1;
        for (int i = 0; i < 4; i++) run_frame("b2b_par", 8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 0, 1'b1);
        for (int i = 0; i < 4; i++) run_frame("b2b_nopar", 8'($urandom), 1'b0, 1'b0, 0, 1'b1);
        data_valid = 1'b0;
        prev_start = -1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_no_parity();
        test_busy_gating();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
